separable_output_first_allocator: RTL

- Separable output-first allocator for the router's switch/VC allocation stages.
- Matches AGENTS_NUM requesting agents (input ports or VCs) to RESOURCES_NUM resources (output ports or VCs).
- Stage 1: one round-robin arbiter per resource selects among requesting agents. Stage 2: one round-robin arbiter per agent selects among the resources that chose it.
- Drop-in alternative to the input-first allocator, with the same ports and the same grant-matrix orientation.

---
 rtl/separable_output_first_allocator_pkg.sv | 16 +
 rtl/separable_output_first_allocator_round_robin_arbiter.sv | 41 ++++
 rtl/separable_output_first_allocator.sv | 52 +++++
 3 files changed

// File: rtl/separable_output_first_allocator_pkg.sv
// Shared defaults and index helpers for the separable output-first allocator.
package separable_output_first_allocator_pkg;

  localparam int DEFAULT_AGENTS_NUM    = 5;
  localparam int DEFAULT_RESOURCES_NUM = 5;

  // A single-entry arbiter still needs a one-bit pointer register.
  function automatic int ptr_width(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

  function automatic int wrap_add(input int base, input int offset, input int count);
    return (base + offset) % count;
  endfunction

endpackage

// File: rtl/separable_output_first_allocator_round_robin_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, pointer advances past the winner.
module round_robin_arbiter
  import separable_output_first_allocator_pkg::*;
#(
  parameter int AGENTS_NUM = DEFAULT_AGENTS_NUM
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [AGENTS_NUM-1:0] requests_i,
  output logic [AGENTS_NUM-1:0] grants_o
);

  localparam int PTR_W = ptr_width(AGENTS_NUM);

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] winner;
  logic             found;

  // Scan from the pointer upward with wrap-around; the first requester wins.
  always_comb begin
    grants_o = '0;
    winner   = '0;
    found    = 1'b0;
    for (int i = 0; i < AGENTS_NUM; i++) begin
      if (!found && requests_i[wrap_add(int'(ptr), i, AGENTS_NUM)]) begin
        found = 1'b1;
        winner = PTR_W'(wrap_add(int'(ptr), i, AGENTS_NUM));
        grants_o[wrap_add(int'(ptr), i, AGENTS_NUM)] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= PTR_W'(wrap_add(int'(winner), 1, AGENTS_NUM));
    end
  end

endmodule

// File: rtl/separable_output_first_allocator.sv
// Separable output-first allocator: resources pick agents, then each agent picks one offer.
module separable_output_first_allocator
  import separable_output_first_allocator_pkg::*;
#(
  parameter int AGENTS_NUM    = DEFAULT_AGENTS_NUM,
  parameter int RESOURCES_NUM = DEFAULT_RESOURCES_NUM
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [AGENTS_NUM-1:0][RESOURCES_NUM-1:0]  requests_i,
  output logic [AGENTS_NUM-1:0][RESOURCES_NUM-1:0]  grants_o
);

  logic [RESOURCES_NUM-1:0][AGENTS_NUM-1:0] resource_requests;
  logic [RESOURCES_NUM-1:0][AGENTS_NUM-1:0] resource_picks;
  logic [AGENTS_NUM-1:0][RESOURCES_NUM-1:0] agent_offers;

  // Column view of the requests feeds stage 1; stage-1 picks are turned back into rows for stage 2.
  always_comb begin
    resource_requests = '0;
    agent_offers      = '0;
    for (int a = 0; a < AGENTS_NUM; a++) begin
      for (int r = 0; r < RESOURCES_NUM; r++) begin
        resource_requests[r][a] = requests_i[a][r];
        agent_offers[a][r]      = resource_picks[r][a];
      end
    end
  end

  for (genvar r = 0; r < RESOURCES_NUM; r++) begin : g_stage1
    round_robin_arbiter #(
      .AGENTS_NUM(AGENTS_NUM)
    ) u_output_arb (
      .clk       (clk),
      .rst       (rst),
      .requests_i(resource_requests[r]),
      .grants_o  (resource_picks[r])
    );
  end

  for (genvar a = 0; a < AGENTS_NUM; a++) begin : g_stage2
    round_robin_arbiter #(
      .AGENTS_NUM(RESOURCES_NUM)
    ) u_input_arb (
      .clk       (clk),
      .rst       (rst),
      .requests_i(agent_offers[a]),
      .grants_o  (grants_o[a])
    );
  end

endmodule
